// File: rtl/pm_loader_pkg.sv
// Shared types and constants for the program-memory loader.
package pm_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Program memory write-port payload
    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } pm_wr_t;

endpackage

// File: rtl/pm_loader_timer.sv
// Inter-byte idle timer; expired is high during the cycle in which the
// count would reach TIMEOUT_CYC.
module loader_timer #(
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned TW          = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else if (clr || !en) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else begin
            cnt     <= cnt + TW'(1);
            expired <= ((cnt + TW'(1)) == LAST);
        end
    end

endmodule

// File: rtl/pm_loader.sv
// Loads a framed, checksummed byte stream into program memory and holds the
// CPU in reset until a verified image is present.
module pm_loader
    import pm_loader_pkg::*;
#(
    parameter logic [7:0]  HDR_BYTE    = HDR_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned TW          = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       err_clr,
    output logic [7:0] pm_wr_addr,
    output logic [7:0] pm_wr_data,
    output logic       pm_wren,
    output logic       cpu_reset,
    output logic       busy,
    output logic       load_ok,
    output logic       err,
    output logic [1:0] err_code,
    output logic [8:0] bytes_loaded
);

    state_t     state;
    state_t     state_next;
    pm_wr_t     pm_wr;
    logic [7:0] addr;
    logic [8:0] count;
    logic [7:0] checksum;
    logic       accept;
    logic       timer_en;
    logic       expired;
    logic       last_byte;
    logic       csum_match;

    assign accept     = in_valid & in_ready;
    assign timer_en   = (state == LEN) || (state == DATA) || (state == CSUM);
    assign last_byte  = ((bytes_loaded + 9'd1) == count);
    assign csum_match = (in_data == checksum);
    assign pm_wr_addr = pm_wr.addr;
    assign pm_wr_data = pm_wr.data;

    loader_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TW          (TW)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (accept),
        .en      (timer_en),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An accepted byte always takes priority over a timeout in the same cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && (in_data == HDR_BYTE)) state_next = LEN;
            end
            LEN: begin
                if (accept)       state_next = DATA;
                else if (expired) state_next = ERR;
            end
            DATA: begin
                if (accept) begin
                    if (last_byte) state_next = CSUM;
                end else if (expired) begin
                    state_next = ERR;
                end
            end
            CSUM: begin
                if (accept)       state_next = csum_match ? IDLE : ERR;
                else if (expired) state_next = ERR;
            end
            ERR: begin
                if (err_clr) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath, write port and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready     <= 1'b1;
            pm_wren      <= 1'b0;
            pm_wr        <= '0;
            cpu_reset    <= 1'b1;
            busy         <= 1'b0;
            load_ok      <= 1'b0;
            err          <= 1'b0;
            err_code     <= ERR_NONE;
            bytes_loaded <= '0;
            checksum     <= '0;
            addr         <= '0;
            count        <= '0;
        end else begin
            pm_wren  <= 1'b0;
            in_ready <= (state_next != ERR);
            busy     <= (state_next == LEN) || (state_next == DATA) || (state_next == CSUM);
            err      <= (state_next == ERR);
            case (state)
                IDLE: begin
                    if (accept && (in_data == HDR_BYTE)) begin
                        cpu_reset    <= 1'b1;
                        load_ok      <= 1'b0;
                        bytes_loaded <= '0;
                        checksum     <= '0;
                    end
                end
                LEN: begin
                    if (accept) begin
                        count <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                        addr  <= '0;
                    end else if (expired) begin
                        err_code <= ERR_TIMEOUT;
                    end
                end
                DATA: begin
                    if (accept) begin
                        pm_wren      <= 1'b1;
                        pm_wr.addr   <= addr;
                        pm_wr.data   <= in_data;
                        addr         <= addr + 8'd1;
                        checksum     <= checksum + in_data;
                        bytes_loaded <= bytes_loaded + 9'd1;
                    end else if (expired) begin
                        err_code <= ERR_TIMEOUT;
                    end
                end
                CSUM: begin
                    if (accept) begin
                        if (csum_match) begin
                            load_ok   <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            err_code <= ERR_CSUM;
                        end
                    end else if (expired) begin
                        err_code <= ERR_TIMEOUT;
                    end
                end
                ERR: begin
                    cpu_reset <= 1'b1;
                    if (err_clr) err_code <= ERR_NONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pm_loader.sv
// Directed bench for pm_loader: framing, checksum, timeout and reset behaviour.
module tb_pm_loader;

    localparam int unsigned TIMEOUT_CYC = 1000;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       err_clr;
    logic [7:0] pm_wr_addr;
    logic [7:0] pm_wr_data;
    logic       pm_wren;
    logic       cpu_reset;
    logic       busy;
    logic       load_ok;
    logic       err;
    logic [1:0] err_code;
    logic [8:0] bytes_loaded;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [256];
    int         wr_cnt    = 0;
    logic [7:0] last_addr = '0;
    logic [7:0] last_data = '0;

    pm_loader #(
        .HDR_BYTE    (8'hA5),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TW          (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .err_clr      (err_clr),
        .pm_wr_addr   (pm_wr_addr),
        .pm_wr_data   (pm_wr_data),
        .pm_wren      (pm_wren),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .load_ok      (load_ok),
        .err          (err),
        .err_code     (err_code),
        .bytes_loaded (bytes_loaded)
    );

    always #5 clk = ~clk;

    // Program memory model, sampled mid-cycle
    always @(negedge clk) begin
        if (reset && pm_wren) begin
            mem[pm_wr_addr] = pm_wr_data;
            last_addr       = pm_wr_addr;
            last_data       = pm_wr_data;
            wr_cnt          = wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic clear_err();
        err_clr  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick(1);
        err_clr  = 1'b0;
        in_valid = 1'b0;
    endtask

    int base;

    initial begin
        reset    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        #12;
        check("rst_in_ready", 16'(in_ready), 16'h1);
        check("rst_wren", 16'(pm_wren), 16'h0);
        check("rst_addr", 16'(pm_wr_addr), 16'h0);
        check("rst_cpu_reset", 16'(cpu_reset), 16'h1);
        check("rst_status", {12'h0, busy, load_ok, err_code}, 16'h0);
        check("rst_bytes", 16'(bytes_loaded), 16'h0);
        tick(1);
        reset = 1'b1;
        tick(2);

        // 1: reset asserted while a write is on the port
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h11); send_byte(8'h22);
        check("t1_wren_before", 16'(pm_wren), 16'h1);
        reset = 1'b0;
        #1;
        check("t1_wren", 16'(pm_wren), 16'h0);
        check("t1_cpu_reset", 16'(cpu_reset), 16'h1);
        check("t1_busy", 16'(busy), 16'h0);
        check("t1_bytes", 16'(bytes_loaded), 16'h0);
        check("t1_wdata", {pm_wr_addr, pm_wr_data}, 16'h0);
        tick(1);
        reset = 1'b1;
        tick(1);
        check("t1_idle_after", {12'h0, in_ready, busy, err_code}, 16'h8);

        // 2: good three-byte load
        base = wr_cnt;
        send_byte(8'hA5);
        check("t2_busy", 16'(busy), 16'h1);
        send_byte(8'h03);
        send_byte(8'h10);
        check("t2_wr0", {7'h0, pm_wren, pm_wr_addr}, 16'h0100);
        check("t2_wd0", 16'(pm_wr_data), 16'h10);
        send_byte(8'h20);
        send_byte(8'h30);
        check("t2_wr2", {pm_wr_addr, pm_wr_data}, 16'h0230);
        check("t2_csum_wait", {14'h0, busy, load_ok}, 16'h2);
        send_byte(8'h60);
        check("t2_load_ok", 16'(load_ok), 16'h1);
        check("t2_cpu_reset", 16'(cpu_reset), 16'h0);
        check("t2_bytes", 16'(bytes_loaded), 16'h3);
        check("t2_busy_done", 16'(busy), 16'h0);
        check("t2_wr_cnt", 16'(wr_cnt - base), 16'h3);
        check("t2_mem", {mem[1], mem[2]}, 16'h2030);
        check("t2_mem0", 16'(mem[0]), 16'h10);

        // 6: stray byte ignored, header restarts and holds CPU again
        send_byte(8'h3C);
        check("t6_stray", {13'h0, busy, load_ok, cpu_reset}, 16'h2);
        send_byte(8'hA5);
        check("t6_hdr", {13'h0, busy, load_ok, cpu_reset}, 16'h5);
        check("t6_bytes", 16'(bytes_loaded), 16'h0);
        send_byte(8'h01); send_byte(8'hA5); send_byte(8'hA5);
        check("t6_hdr_as_data", {13'h0, busy, load_ok, cpu_reset}, 16'h2);
        check("t6_mem0", 16'(mem[0]), 16'hA5);

        // 3: checksum mismatch, then err_clr with a simultaneous byte
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h04);
        check("t3_err", {12'h0, err, in_ready, err_code}, 16'h9);
        check("t3_cpu_reset", 16'(cpu_reset), 16'h1);
        check("t3_load_ok", 16'(load_ok), 16'h0);
        tick(3);
        check("t3_err_hold", {12'h0, err, in_ready, err_code}, 16'h9);
        clear_err();
        check("t3_clr", {12'h0, err, in_ready, err_code}, 16'h4);
        check("t3_no_accept", 16'(busy), 16'h0);
        check("t3_cpu_held", 16'(cpu_reset), 16'h1);

        // 4: LEN 0x00 means 256 bytes, address wraps to 0xFF
        base = wr_cnt;
        send_byte(8'hA5); send_byte(8'h00);
        for (int i = 0; i < 256; i++) send_byte(8'h01);
        check("t4_busy", 16'(busy), 16'h1);
        send_byte(8'h00);
        check("t4_last", {last_addr, last_data}, 16'hFF01);
        check("t4_bytes", 16'(bytes_loaded), 16'h100);
        check("t4_load_ok", {14'h0, load_ok, cpu_reset}, 16'h2);
        check("t4_wr_cnt", 16'(wr_cnt - base), 16'h100);

        // 5: inter-byte timeout, then a byte on the expiry cycle
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h11);
        tick(TIMEOUT_CYC - 1);
        check("t5_pre_expiry", {13'h0, busy, err, in_ready}, 16'h5);
        tick(1);
        check("t5_timeout", {12'h0, err, in_ready, err_code}, 16'hA);
        check("t5_cpu_reset", 16'(cpu_reset), 16'h1);
        clear_err();
        check("t5_clr", {12'h0, err, in_ready, err_code}, 16'h4);
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h11);
        tick(TIMEOUT_CYC - 1);
        send_byte(8'h22);
        check("t5_expiry_win", {12'h0, busy, err, err_code}, 16'h8);
        check("t5_expiry_wr", {7'h0, pm_wren, pm_wr_data}, 16'h0122);
        send_byte(8'h33); send_byte(8'h44); send_byte(8'hAA);
        check("t5_load_ok", {14'h0, load_ok, cpu_reset}, 16'h2);
        check("t5_bytes", 16'(bytes_loaded), 16'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
